// File: rtl/hog_pkg.sv
// Shared constants and drain-FSM state type for the HOG cell histogram accumulator.
package hog_pkg;

  localparam int MAG_W    = 16;
  localparam int CODE_W   = 4;
  localparam int N_BINS   = 9;
  localparam int CELL_PIX = 64;
  localparam int CNT_W    = $clog2(CELL_PIX);
  // Extra bits let 64 full-scale magnitudes accumulate without wrapping.
  localparam int ACC_W    = MAG_W + CNT_W;
  localparam int IDX_W    = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_t;

endpackage

// File: rtl/cell_hist_acc_bank.sv
// hist_bank: one 9-entry accumulator bank with add, whole-bank clear and read mux.
module hist_bank
  import hog_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              add_en,
  input  logic [CODE_W-1:0] add_code,
  input  logic [MAG_W-1:0]  add_mag,
  input  logic              clr,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [ACC_W-1:0]  rd_val
);

  logic [ACC_W-1:0] acc [N_BINS];

  // NOTE: the bins are reset because a reset must discard partial cells;
  // sequential state is written with <= so all bins update on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < N_BINS; b++) acc[b] <= '0;
    end else if (clr) begin
      for (int b = 0; b < N_BINS; b++) acc[b] <= '0;
    end else if (add_en && (add_code < CODE_W'(N_BINS))) begin
      acc[add_code] <= acc[add_code] + ACC_W'(add_mag);
    end
  end

  // NOTE: default assignment first so the out-of-range path cannot infer a latch.
  always_comb begin
    rd_val = '0;
    if (rd_idx < IDX_W'(N_BINS)) rd_val = acc[rd_idx];
  end

endmodule

// File: rtl/cell_hist_acc.sv
// 8x8-cell orientation histogram with ping-pong banks and serial bin drain.
// Optional HIST_CODE_ERR_EN adds a sticky o_code_err flag for illegal codes.
module cell_hist_acc
  import hog_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_in_ready,
  input  logic [CODE_W-1:0] i_code,
  input  logic [MAG_W-1:0]  i_mag,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [IDX_W-1:0]  o_bin_idx,
  output logic [ACC_W-1:0]  o_bin_val,
  output logic              o_last
`ifdef HIST_CODE_ERR_EN
  ,
  output logic              o_code_err
`endif
);

  logic             wr_bank;
  logic             rd_bank;
  logic             ready_en;
  logic [1:0]       full;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] idx;
  drain_state_t     state;

  logic             accept;
  logic             fill_done;
  logic             bin_taken;
  logic             drain_done;
  logic [1:0]       add_en;
  logic [1:0]       clr;
  logic [1:0]       set_full;
  logic [ACC_W-1:0] bank_val [2];

  assign o_in_ready = ready_en && !full[wr_bank];
  assign accept     = i_valid && o_in_ready;
  assign fill_done  = accept && (count == CNT_W'(CELL_PIX - 1));

  // DRAIN tracks the read bank's full flag directly, giving the one-cycle latency.
  assign state      = full[rd_bank] ? ST_DRAIN : ST_IDLE;
  assign o_valid    = (state == ST_DRAIN);
  assign bin_taken  = o_valid && i_ready;
  assign drain_done = bin_taken && (idx == IDX_W'(N_BINS - 1));

  assign add_en   = {accept && wr_bank, accept && !wr_bank};
  assign clr      = {drain_done && rd_bank, drain_done && !rd_bank};
  assign set_full = {fill_done && wr_bank, fill_done && !wr_bank};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    hist_bank u_bank (
      .clk      (clk),
      .rst      (rst),
      .add_en   (add_en[b]),
      .add_code (i_code),
      .add_mag  (i_mag),
      .clr      (clr[b]),
      .rd_idx   (idx),
      .rd_val   (bank_val[b])
    );
  end

  assign o_bin_idx = idx;
  assign o_bin_val = bank_val[rd_bank];
  assign o_last    = o_valid && (idx == IDX_W'(N_BINS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      ready_en <= 1'b0;
      full     <= '0;
      count    <= '0;
      idx      <= '0;
    end else begin
      ready_en <= 1'b1;
      // Set and clear never target the same bank: fill needs it empty, drain needs it full.
      full     <= (full | set_full) & ~clr;
      if (accept)     count   <= fill_done ? '0 : count + CNT_W'(1);
      if (fill_done)  wr_bank <= ~wr_bank;
      if (bin_taken)  idx     <= drain_done ? '0 : idx + IDX_W'(1);
      if (drain_done) rd_bank <= ~rd_bank;
    end
  end

`ifdef HIST_CODE_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_code_err <= 1'b0;
    end else if (accept && (i_code >= CODE_W'(N_BINS))) begin
      o_code_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cell_hist_acc.sv
// Directed bench for cell_hist_acc: a reference model pushes expected bins to a
// queue as each cell completes; a monitor pops and compares every accepted bin.
module tb_cell_hist_acc;
  import hog_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_valid;
  logic              o_in_ready;
  logic [CODE_W-1:0] i_code;
  logic [MAG_W-1:0]  i_mag;
  logic              o_valid;
  logic              i_ready;
  logic [IDX_W-1:0]  o_bin_idx;
  logic [ACC_W-1:0]  o_bin_val;
  logic              o_last;
`ifdef HIST_CODE_ERR_EN
  logic              o_code_err;
`endif

  always #5 clk = ~clk;

  cell_hist_acc dut (
`ifdef HIST_CODE_ERR_EN
    .o_code_err (o_code_err),
`endif
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .o_in_ready (o_in_ready),
    .i_code     (i_code),
    .i_mag      (i_mag),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_bin_idx  (o_bin_idx),
    .o_bin_val  (o_bin_val),
    .o_last     (o_last)
  );

  typedef struct {
    logic [31:0] idx;
    logic [31:0] val;
    logic [31:0] last;
  } exp_t;

  exp_t        sb[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          bins_seen   = 0;
  longint      model_acc[N_BINS];
  int          pix_cnt     = 0;
  logic [31:0] held_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < N_BINS; b++) model_acc[b] = 0;
    pix_cnt = 0;
  endtask

  task automatic model_accept(input logic [CODE_W-1:0] code, input logic [MAG_W-1:0] mag);
    if (int'(code) < N_BINS) model_acc[code] += longint'(mag);
    pix_cnt++;
    if (pix_cnt == CELL_PIX) begin
      for (int b = 0; b < N_BINS; b++) begin
        exp_t e;
        e.idx  = 32'(b);
        e.val  = 32'(model_acc[b]);
        e.last = (b == N_BINS - 1) ? 32'd1 : 32'd0;
        sb.push_back(e);
      end
      model_reset();
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [CODE_W-1:0] code, input logic [MAG_W-1:0] mag);
    int t = 0;
    i_valid = 1'b1;
    i_code  = code;
    i_mag   = mag;
    @(negedge clk);
    while (o_in_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      vectors++;
      miscompares++;
      $error("FAIL send_timeout observed ready=%b expected ready=1", o_in_ready);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    if (t < 200) model_accept(code, mag);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && (sb.size() != 0 || o_valid === 1'b1); i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_done_queue_empty", 32'(sb.size()), 32'd0);
  endtask

  // Outputs are stable at the falling edge; a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (rst === 1'b0 && o_valid === 1'b1 && i_ready === 1'b1) begin
      bins_seen++;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_bin observed idx=%0d val=0x%0h expected no bin", o_bin_idx, o_bin_val);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("bin_idx",  32'(o_bin_idx), e.idx);
        check("bin_val",  32'(o_bin_val), e.val);
        check("bin_last", 32'(o_last),    e.last);
      end
    end
  end

  initial begin
    rst     = 1'b1;
    i_valid = 1'b0;
    i_code  = '0;
    i_mag   = '0;
    i_ready = 1'b1;
    model_reset();

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(o_in_ready), 32'd0);
    check("rst_valid",    32'(o_valid),    32'd0);
    check("rst_last",     32'(o_last),     32'd0);
    check("rst_bin_idx",  32'(o_bin_idx),  32'd0);
    check("rst_bin_val",  32'(o_bin_val),  32'd0);
`ifdef HIST_CODE_ERR_EN
    check("rst_code_err", 32'(o_code_err), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("ready_before_first_clk", 32'(o_in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("ready_after_rst", 32'(o_in_ready), 32'd1);

    // Single bin, minimum latency, 9 consecutive beats
    for (int n = 0; n < CELL_PIX; n++) send(4'd2, 16'd100);
    for (int k = 0; k < N_BINS; k++) begin
      check("t1_valid_run", 32'(o_valid),   32'd1);
      check("t1_idx_run",   32'(o_bin_idx), 32'(k));
      @(posedge clk);
      #1;
    end
    check("t1_valid_after", 32'(o_valid), 32'd0);
    wait_drain();

    // All bins populated: code n%9, magnitude n
    for (int n = 0; n < CELL_PIX; n++) send(4'(n % N_BINS), 16'(n));
    wait_drain();

    // Backpressure: two cells fill both banks, then back-to-back drain
    i_ready = 1'b0;
    for (int n = 0; n < CELL_PIX; n++) send(4'd0, 16'd7);
    check("t3_valid_cell1", 32'(o_valid), 32'd1);
    held_val = 32'(o_bin_val);
    for (int n = 0; n < CELL_PIX; n++) send(4'd5, 16'd11);
    check("t3_ready_drop",    32'(o_in_ready), 32'd0);
    check("t3_hold_idx",      32'(o_bin_idx),  32'd0);
    check("t3_hold_val",      32'(o_bin_val),  held_val);
    repeat (5) @(posedge clk);
    #1;
    check("t3_hold_val_late", 32'(o_bin_val),  held_val);
    check("t3_hold_valid",    32'(o_valid),    32'd1);
    i_ready = 1'b1;
    for (int k = 0; k < N_BINS; k++) begin
      @(negedge clk);
      check("t3_ready_low_drain", 32'(o_in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    check("t3_ready_rise",   32'(o_in_ready), 32'd1);
    check("t3_b2b_valid",    32'(o_valid),    32'd1);
    check("t3_b2b_idx",      32'(o_bin_idx),  32'd0);
    wait_drain();

    // Full-scale magnitudes into the last bin
    for (int n = 0; n < CELL_PIX; n++) send(4'd8, 16'hFFFF);
    check("t4_model_no_wrap", 32'(model_acc[8]), 32'd0);
    check("t4_bin8_head", 32'(sb[8].val), 32'h003F_FFC0);
    wait_drain();

    // One illegal code among 63 legal pixels
`ifdef HIST_CODE_ERR_EN
    check("t5_err_before", 32'(o_code_err), 32'd0);
`endif
    for (int n = 0; n < CELL_PIX; n++) begin
      if (n == 20) send(4'd12, 16'd1);
      else         send(4'd0,  16'd1);
    end
    check("t5_bin0_head", 32'(sb[0].val), 32'd63);
    wait_drain();
`ifdef HIST_CODE_ERR_EN
    check("t5_err_sticky", 32'(o_code_err), 32'd1);
`endif

    // Reset mid-cell discards the partial histogram
    for (int n = 0; n < 30; n++) send(4'd4, 16'd9);
    rst = 1'b1;
    model_reset();
    #1;
    check("t6_ready_in_rst", 32'(o_in_ready), 32'd0);
    check("t6_valid_in_rst", 32'(o_valid),    32'd0);
`ifdef HIST_CODE_ERR_EN
    check("t6_err_cleared",  32'(o_code_err), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int n = 0; n < CELL_PIX; n++) send(4'd1, 16'd5);
    check("t6_bin1_head", 32'(sb[1].val), 32'd320);
    wait_drain();
    repeat (20) @(posedge clk);
    #1;
    check("total_bins_seen", 32'(bins_seen), 32'(7 * N_BINS));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
